// File: rtl/qinv_pkg.sv
// qinv_pkg: shared types, tables and helpers for the inverse Twofish q0 word unit.
// Holds the FSM state encoding, the forward (T0..T3) and inverse (iT0..iT3)
// nibble tables, and the small nibble helpers used by both directions.
package qinv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Forward Twofish q0 nibble tables.
  localparam logic [3:0] T0 [16] = '{4'h8, 4'h1, 4'h7, 4'hD, 4'h6, 4'hF, 4'h3, 4'h2,
                                     4'h0, 4'hB, 4'h5, 4'h9, 4'hE, 4'hC, 4'hA, 4'h4};
  localparam logic [3:0] T1 [16] = '{4'hE, 4'hC, 4'hB, 4'h8, 4'h1, 4'h2, 4'h3, 4'h5,
                                     4'hF, 4'h4, 4'hA, 4'h6, 4'h7, 4'h0, 4'h9, 4'hD};
  localparam logic [3:0] T2 [16] = '{4'hB, 4'hA, 4'h5, 4'hE, 4'h6, 4'hD, 4'h9, 4'h0,
                                     4'hC, 4'h8, 4'hF, 4'h3, 4'h2, 4'h4, 4'h7, 4'h1};
  localparam logic [3:0] T3 [16] = '{4'hD, 4'h7, 4'hF, 4'h4, 4'h1, 4'h2, 4'h6, 4'hE,
                                     4'h9, 4'hB, 4'h3, 4'h0, 4'h8, 4'h5, 4'hC, 4'hA};

  // Inverse nibble tables: ITn[Tn[i]] == i.
  localparam logic [3:0] IT0 [16] = '{4'h8, 4'h1, 4'h7, 4'h6, 4'hF, 4'hA, 4'h4, 4'h2,
                                      4'h0, 4'hB, 4'hE, 4'h9, 4'hD, 4'h3, 4'hC, 4'h5};
  localparam logic [3:0] IT1 [16] = '{4'hD, 4'h4, 4'h5, 4'h6, 4'h9, 4'h7, 4'hB, 4'hC,
                                      4'h3, 4'hE, 4'hA, 4'h2, 4'h1, 4'hF, 4'h0, 4'h8};
  localparam logic [3:0] IT2 [16] = '{4'h7, 4'hF, 4'hC, 4'hB, 4'hD, 4'h2, 4'h4, 4'hE,
                                      4'h9, 4'h6, 4'h1, 4'h0, 4'h8, 4'h5, 4'h3, 4'hA};
  localparam logic [3:0] IT3 [16] = '{4'hB, 4'h4, 4'h5, 4'hA, 4'h3, 4'hD, 4'h6, 4'h1,
                                      4'hC, 4'h8, 4'hF, 4'h9, 4'hE, 4'h0, 4'h7, 4'h2};

  // Rotate a nibble right by one bit.
  function automatic logic [3:0] ror4_1(input logic [3:0] x);
    return {x[0], x[3:1]};
  endfunction

  // Undo the nibble mix L(a) = a ^ ROR4(a,1) ^ (8a mod 16).
  function automatic logic [3:0] linv4(input logic [3:0] c);
    logic [3:0] r;
    r[3] = c[3];
    r[2] = c[2] ^ r[3];
    r[1] = c[1] ^ r[2];
    r[0] = c[0] ^ r[1];
    return r;
  endfunction

  // Forward Twofish q0 byte permutation.
  function automatic logic [7:0] q0_fwd(input logic [7:0] x);
    logic [3:0] a0, b0, a1, b1, a2, b2, a3, b3;
    a0 = x[7:4];
    b0 = x[3:0];
    a1 = a0 ^ b0;
    b1 = a0 ^ ror4_1(b0) ^ {a0[0], 3'b000};
    a2 = T0[a1];
    b2 = T1[b1];
    a3 = a2 ^ b2;
    b3 = a2 ^ ror4_1(b2) ^ {a2[0], 3'b000};
    return {T3[b3], T2[a3]};
  endfunction

endpackage

// File: rtl/q0_inv_byte.sv
// q0_inv_byte: combinational inverse of the Twofish q0 byte permutation.
// Walks the forward rounds backwards: inverse tables, then undo the nibble mix.
module q0_inv_byte
  import qinv_pkg::*;
(
  input  logic [7:0] i_y,
  output logic [7:0] o_x
);

  logic [3:0] w_a4, w_b4, w_a3, w_b3, w_a2, w_b2, w_a1, w_b1, w_a0, w_b0;

  assign w_a4 = i_y[3:0];
  assign w_b4 = i_y[7:4];

  // Second round undone.
  assign w_a3 = IT2[w_a4];
  assign w_b3 = IT3[w_b4];
  assign w_a2 = linv4(w_b3 ^ ror4_1(w_a3));
  assign w_b2 = w_a2 ^ w_a3;

  // First round undone.
  assign w_a1 = IT0[w_a2];
  assign w_b1 = IT1[w_b2];
  assign w_a0 = linv4(w_b1 ^ ror4_1(w_a1));
  assign w_b0 = w_a0 ^ w_a1;

  assign o_x = {w_a0, w_b0};

endmodule

// File: rtl/q0_inv_word.sv
// q0_inv_word: applies inverse q0 to every byte of an NBYTES-wide word, one
// byte per clock, then holds the result until the downstream handshake.
// Optional build macro QINV_SELFCHECK_EN: re-applies forward q0 to each
// recovered byte and raises a sticky err on any disagreement.
//
// Handshake: a word is taken on a rising edge where in_valid && in_ready;
// a result is delivered on a rising edge where out_valid && out_ready.
// out_data is stable while out_valid is high and not yet accepted.
module q0_inv_word
  import qinv_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_data,
  output logic                  err,
  output logic [1:0]            dbg_state
);

  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_cnt;
  logic [8*NBYTES-1:0] r_hold;
  logic [8*NBYTES-1:0] r_out;
  logic [7:0]          w_sel;
  logic [7:0]          w_inv;
  logic                w_accept;

  // Pick the held byte addressed by the byte counter.
  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (r_cnt == CW'(k)) w_sel = r_hold[8*k +: 8];
    end
  end

  q0_inv_byte u_inv (
    .i_y (w_sel),
    .o_x (w_inv)
  );

  // Next-state and handshake decode; DONE may hand off and accept in one cycle.
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    w_accept = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == LAST) w_next = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            w_accept = 1'b1;
            w_next   = BUSY;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Input capture, byte counter and per-byte result write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_hold <= '0;
      r_out  <= '0;
    end else if (w_accept) begin
      r_hold <= in_data;
      r_cnt  <= '0;
    end else if (r_state == BUSY) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (r_cnt == CW'(k)) r_out[8*k +: 8] <= w_inv;
      end
      if (r_cnt != LAST) r_cnt <= r_cnt + CW'(1);
    end
  end

  assign out_valid = (r_state == DONE);
  assign out_data  = r_out;
  assign dbg_state = r_state;

`ifdef QINV_SELFCHECK_EN
  logic r_err;

  // Sticky flag: recovered byte must map back onto the held byte.
  always_ff @(posedge clk) begin
    if (rst)                                               r_err <= 1'b0;
    else if ((r_state == BUSY) && (q0_fwd(w_inv) != w_sel)) r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
